// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer-facing bundle of the single-clock flagged FIFO.
// The FIFO drives the outputs through the slave modport. A producer or consumer uses the master modport.
interface sync_fifo_flags_if #(
    parameter int WIDTH = 8,
    parameter int PTR   = 4
);
    logic             sclr;
    logic             wren;
    logic [WIDTH-1:0] datain;
    logic             rden;
    logic [WIDTH-1:0] dataout;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [PTR:0]     usedw;
    logic             overflow;
    logic             underflow;

    modport master (
        output sclr, wren, datain, rden,
        input  dataout, full, empty, almost_full, almost_empty, usedw, overflow, underflow
    );

    modport slave (
        input  sclr, wren, datain, rden,
        output dataout, full, empty, almost_full, almost_empty, usedw, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO on a dual-port RAM. It provides an exact fill count, almost-full and almost-empty thresholds,
// sticky overflow and underflow flags, and an optional show-ahead read port.
module sync_fifo_flags #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int PTR       = 4,
    parameter int AF_LEVEL  = 14,
    parameter int AE_LEVEL  = 2,
    parameter bit SHOWAHEAD = 1'b0
) (
    input  logic              clk,
    input  logic              reset_,
    sync_fifo_flags_if.slave  bus
);

    if (DEPTH != 2**PTR) begin : g_bad_depth
        $error("sync_fifo_flags: DEPTH (%0d) must equal 2**PTR (PTR=%0d)", DEPTH, PTR);
    end
    if (!(AE_LEVEL >= 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
        $error("sync_fifo_flags: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    localparam logic [PTR:0] PTR_ONE  = (PTR+1)'(1);
    localparam logic [PTR:0] AF_CNT   = (PTR+1)'(AF_LEVEL);
    localparam logic [PTR:0] AE_CNT   = (PTR+1)'(AE_LEVEL);

    logic [WIDTH-1:0] ram [DEPTH];
    logic [PTR:0]     wrptr;
    logic [PTR:0]     rdptr;
    logic             full_int;
    logic             empty_int;
    logic             clear;
    logic             wr_accept;
    logic             rd_accept;
    logic             overflow_q;
    logic             underflow_q;

    // Flags come straight from the registered pointers. The extra wrap bit tells full apart from empty.
    assign empty_int = (wrptr == rdptr);
    assign full_int  = (wrptr[PTR] != rdptr[PTR]) && (wrptr[PTR-1:0] == rdptr[PTR-1:0]);
    assign clear     = !reset_ || bus.sclr;
    assign wr_accept = bus.wren && !full_int && !clear;
    assign rd_accept = bus.rden && !empty_int && !clear;

    assign bus.full         = full_int;
    assign bus.empty        = empty_int;
    assign bus.usedw        = wrptr - rdptr;
    assign bus.almost_full  = (bus.usedw >= AF_CNT);
    assign bus.almost_empty = (bus.usedw <= AE_CNT);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    // NOTE: the storage array has no reset. Clearing the FIFO only rewinds the pointers, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (wr_accept)
            ram[wrptr[PTR-1:0]] <= bus.datain;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every process sees pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            wrptr       <= '0;
            rdptr       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_accept)
                wrptr <= wrptr + PTR_ONE;
            if (rd_accept)
                rdptr <= rdptr + PTR_ONE;
            if (bus.wren && full_int)
                overflow_q <= 1'b1;
            if (bus.rden && empty_int)
                underflow_q <= 1'b1;
        end
    end

    if (SHOWAHEAD) begin : g_showahead
        // The head word is presented directly. When the FIFO is empty the output is forced to zero.
        assign bus.dataout = empty_int ? '0 : ram[rdptr[PTR-1:0]];
    end else begin : g_registered
        logic [WIDTH-1:0] dataout_q;

        always_ff @(posedge clk) begin
            if (clear)
                dataout_q <= '0;
            else if (rd_accept)
                dataout_q <= ram[rdptr[PTR-1:0]];
        end

        assign bus.dataout = dataout_q;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench. It drives identical stimulus into a registered-read FIFO and a show-ahead FIFO,
// then compares every cycle against a queue model.
module tb_sync_fifo_flags;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int PTR   = 4;

    logic clk    = 1'b0;
    logic reset_ = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_flags_if #(.WIDTH(WIDTH), .PTR(PTR)) bus_reg ();
    sync_fifo_flags_if #(.WIDTH(WIDTH), .PTR(PTR)) bus_sa ();

    sync_fifo_flags #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .PTR(PTR),
        .AF_LEVEL(14), .AE_LEVEL(2), .SHOWAHEAD(1'b0)
    ) dut_reg (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus_reg.slave)
    );

    sync_fifo_flags #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .PTR(PTR),
        .AF_LEVEL(14), .AE_LEVEL(2), .SHOWAHEAD(1'b1)
    ) dut_sa (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus_sa.slave)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];
    bit         exp_valid = 1'b0;
    bit         armed     = 1'b0;
    bit         m_ovf     = 1'b0;
    bit         m_udf     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model status {full, empty, almost_full, almost_empty, overflow, underflow, usedw}
    function automatic logic [10:0] exp_status();
        int cnt;
        cnt = model_q.size();
        return {cnt == DEPTH, cnt == 0, cnt >= 14, cnt <= 2, m_ovf, m_udf, 5'(cnt)};
    endfunction

    // One stimulus cycle. Inputs change on the falling edge. The model advances to the state expected after the next rising edge.
    task automatic drive(input bit w, input logic [7:0] d, input bit r, input bit s = 1'b0, input bit rst = 1'b0);
        int cnt;
        @(negedge clk);
        reset_         = !rst;
        bus_reg.wren   = w;  bus_sa.wren   = w;
        bus_reg.datain = d;  bus_sa.datain = d;
        bus_reg.rden   = r;  bus_sa.rden   = r;
        bus_reg.sclr   = s;  bus_sa.sclr   = s;
        cnt       = model_q.size();
        exp_valid = 1'b0;
        if (rst || s) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            exp_q.push_back(8'h00);
            exp_valid = 1'b1;
        end else begin
            if (w && cnt == DEPTH) m_ovf = 1'b1;
            if (r && cnt == 0)     m_udf = 1'b1;
            if (r && cnt != 0) begin
                exp_q.push_back(model_q.pop_front());
                exp_valid = 1'b1;
            end
            if (w && cnt != DEPTH) model_q.push_back(d);
        end
        armed = 1'b1;
    endtask

    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    // Monitor: flags every cycle, the show-ahead head every cycle, and registered read data whenever a read or clear was issued.
    always @(posedge clk) begin
        #2;
        if (armed) begin
            check("status_reg", 32'({bus_reg.full, bus_reg.empty, bus_reg.almost_full, bus_reg.almost_empty,
                                     bus_reg.overflow, bus_reg.underflow, bus_reg.usedw}), 32'(exp_status()));
            check("status_sa", 32'({bus_sa.full, bus_sa.empty, bus_sa.almost_full, bus_sa.almost_empty,
                                    bus_sa.overflow, bus_sa.underflow, bus_sa.usedw}), 32'(exp_status()));
            check("sa_dataout", 32'(bus_sa.dataout), (model_q.size() != 0) ? 32'(model_q[0]) : 32'h0);
            if (exp_valid) begin
                check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0)
                    check("reg_dataout", 32'(bus_reg.dataout), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        bus_reg.wren = 1'b0; bus_reg.rden = 1'b0; bus_reg.sclr = 1'b0; bus_reg.datain = '0;
        bus_sa.wren  = 1'b0; bus_sa.rden  = 1'b0; bus_sa.sclr  = 1'b0; bus_sa.datain  = '0;

        drive(0, 8'h00, 0, 0, 1);
        drive(0, 8'h00, 0, 0, 1);
        settle();
        check("rst_empty", 32'(bus_reg.empty), 32'd1);
        check("rst_dataout", 32'(bus_reg.dataout), 32'h0);

        // Fill 0x01..0x10. almost_full first rises at 14 words.
        for (int i = 1; i <= 16; i++) begin
            drive(1, 8'(i), 0);
            if (i == 13) begin
                settle();
                check("af_at13", 32'(bus_reg.almost_full), 32'd0);
            end
            if (i == 14) begin
                settle();
                check("af_at14", 32'(bus_reg.almost_full), 32'd1);
            end
        end
        settle();
        check("fill_full", 32'(bus_reg.full), 32'd1);
        check("fill_usedw", 32'(bus_reg.usedw), 32'd16);

        // Write into the full FIFO, then drain it.
        drive(1, 8'hAA, 0);
        settle();
        check("ovf_set", 32'(bus_reg.overflow), 32'd1);
        check("ovf_usedw", 32'(bus_reg.usedw), 32'd16);
        for (int i = 0; i < 16; i++) drive(0, 8'h00, 1);
        settle();
        check("drain_empty", 32'(bus_reg.empty), 32'd1);
        check("drain_last", 32'(bus_reg.dataout), 32'h10);

        // Read the empty FIFO, then issue a simultaneous read and write while it is empty.
        drive(0, 8'h00, 1);
        settle();
        check("udf_set", 32'(bus_reg.underflow), 32'd1);
        drive(1, 8'h33, 1);
        settle();
        check("rw_empty_usedw", 32'(bus_reg.usedw), 32'd1);
        drive(0, 8'h00, 1);
        drive(0, 8'h00, 0, 1);

        // Wrap-around: hold five words while streaming 40 read+write cycles.
        for (int i = 0; i < 5; i++) drive(1, 8'(8'h40 + i), 0);
        for (int i = 0; i < 40; i++) drive(1, 8'(8'h80 + i), 1);
        settle();
        check("wrap_usedw", 32'(bus_reg.usedw), 32'd5);
        check("wrap_errs", 32'({bus_reg.overflow, bus_reg.underflow}), 32'd0);
        for (int i = 0; i < 5; i++) drive(0, 8'h00, 1);
        settle();
        check("wrap_last", 32'(bus_reg.dataout), 32'hA7);

        // Show-ahead visibility.
        drive(1, 8'h5A, 0);
        settle();
        check("sa_visible", 32'(bus_sa.dataout), 32'h5A);
        drive(0, 8'h00, 1);
        settle();
        check("sa_after_read", 32'({bus_sa.empty, bus_sa.dataout}), 32'h100);

        // Mid-stream sclr at nine words, with both error flags set first.
        drive(0, 8'h00, 1);
        for (int i = 0; i < 16; i++) drive(1, 8'(8'hD0 + i), 0);
        drive(1, 8'hEE, 0);
        for (int i = 0; i < 7; i++) drive(0, 8'h00, 1);
        drive(0, 8'h00, 0, 1);
        settle();
        check("sclr_state", 32'({bus_reg.usedw, bus_reg.empty, bus_reg.overflow, bus_reg.underflow, bus_reg.dataout}),
              32'({5'd0, 1'b1, 1'b0, 1'b0, 8'h00}));
        drive(1, 8'hC3, 0);
        drive(0, 8'h00, 1);
        settle();
        check("sclr_new_word", 32'(bus_reg.dataout), 32'hC3);

        // Mid-stream reset at nine words.
        for (int i = 0; i < 9; i++) drive(1, 8'(8'h60 + i), 0);
        drive(1, 8'hFF, 1, 0, 1);
        settle();
        check("rst_mid_state", 32'({bus_reg.usedw, bus_reg.empty, bus_reg.dataout}), 32'({5'd0, 1'b1, 8'h00}));
        drive(1, 8'h3C, 0);
        drive(0, 8'h00, 1);
        drive(0, 8'h00, 0);
        drive(0, 8'h00, 0);
        settle();
        check("rst_new_word", 32'(bus_reg.dataout), 32'h3C);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
